// File: rtl/alu_mul.sv
// Sequential shift-and-add unsigned multiplier: data_wl CALC cycles, then the
// product is presented as two words (low half, then high half).
module alu_mul #(
    parameter int data_wl = 16
) (
    input  logic               clk,
    input  logic               a_reset,
    input  logic [data_wl-1:0] a_in,
    input  logic [data_wl-1:0] b_in,
    input  logic               ld,
    output logic [data_wl-1:0] p_out,
    output logic               valid,
    output logic               busy,
    output logic               z_flag,
    output logic               ovr_flag
);

    localparam int CW = $clog2(data_wl + 1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        OUTL = 4'b0100,
        OUTH = 4'b1000
    } state_t;

    state_t                 state_q, state_d;
    logic [data_wl-1:0]     mcand_q, mcand_d;
    logic [2*data_wl-1:0]   prod_q, prod_d;
    logic                   carry_q, carry_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [data_wl:0]       sum;

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiplier bits live in the low half and shift out as the partial
    // product shifts in from the top, so one register holds both.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum     = {carry_q, prod_q[2*data_wl-1:data_wl]};
        if (prod_q[0])
            sum = {1'b0, prod_q[2*data_wl-1:data_wl]} + {1'b0, mcand_q};

        case (state_q)
            IDLE: begin
                if (ld) begin
                    mcand_d = a_in;
                    prod_d  = {{data_wl{1'b0}}, b_in};
                    carry_d = 1'b0;
                    cnt_d   = CW'(data_wl);
                    state_d = CALC;
                end
            end
            CALC: begin
                prod_d  = {sum, prod_q[data_wl-1:1]};
                carry_d = 1'b0;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = OUTL;
            end
            OUTL:    state_d = OUTH;
            OUTH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_out    = '0;
        valid    = 1'b0;
        z_flag   = 1'b0;
        ovr_flag = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            OUTL: begin
                p_out    = prod_q[data_wl-1:0];
                valid    = 1'b1;
                z_flag   = (prod_q == '0);
                ovr_flag = |prod_q[2*data_wl-1:data_wl];
            end
            OUTH: begin
                p_out    = prod_q[2*data_wl-1:data_wl];
                valid    = 1'b1;
                z_flag   = (prod_q == '0);
                ovr_flag = |prod_q[2*data_wl-1:data_wl];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul.sv
// Self-checking bench for alu_mul: directed literal cases plus a long random
// run compared every cycle against a latency/arithmetic reference model.
module tb_alu_mul;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         a_reset = 1'b1;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ld = 1'b0;
    logic [W-1:0] p_out;
    logic         valid, busy, z_flag, ovr_flag;

    int checks = 0;
    int errors = 0;
    int nops   = 0;

    alu_mul #(.data_wl(W)) dut (
        .clk(clk), .a_reset(a_reset), .a_in(a_in), .b_in(b_in), .ld(ld),
        .p_out(p_out), .valid(valid), .busy(busy), .z_flag(z_flag), .ovr_flag(ovr_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = cycles since the accepting edge (-1 when idle); the
    // product is plain 2W-bit arithmetic captured at acceptance.
    int             age = -1;
    logic [2*W-1:0] mprod = '0;

    always @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            age   <= -1;
            mprod <= '0;
        end else if (age < 0) begin
            if (ld) begin
                age   <= 0;
                mprod <= (2*W)'(a_in) * (2*W)'(b_in);
                nops  <= nops + 1;
            end
        end else if (age == W + 1) begin
            age <= -1;
        end else begin
            age <= age + 1;
        end
    end

    always @(negedge clk) begin
        logic         e_valid, e_busy, e_z, e_ovr;
        logic [W-1:0] e_p;
        e_busy  = (age >= 0);
        e_valid = (age == W) || (age == W + 1);
        e_p     = (age == W) ? mprod[W-1:0] : (age == W + 1) ? mprod[2*W-1:W] : '0;
        e_z     = e_valid && (mprod == '0);
        e_ovr   = e_valid && (mprod[2*W-1:W] != '0);
        chk("outputs{busy,valid,z,ovr,p}", {busy, valid, z_flag, ovr_flag, p_out},
            {e_busy, e_valid, e_z, e_ovr, e_p});
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic hold);
        @(posedge clk); #2;
        a_in = a; b_in = b; ld = 1'b1;
        @(posedge clk); #2;
        if (!hold) ld = 1'b0;
    endtask

    task automatic wait_result(output logic [W-1:0] lo, output logic [W-1:0] hi,
                               output logic z, output logic ovr, output int n);
        lo = '0; hi = '0; z = 1'b0; ovr = 1'b0; n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (valid) break;
            if (n > 40) begin
                chk("result_timeout", 64'(n), 64'(W + 1));
                return;
            end
        end
        lo = p_out; z = z_flag; ovr = ovr_flag;
        @(negedge clk);
        chk("valid_second_word", 64'(valid), 64'd1);
        hi = p_out;
        chk("flags_stable", {62'd0, z_flag, ovr_flag}, {62'd0, z, ovr});
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return W'(1) << $urandom_range(0, W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] lo, hi;
        logic         z, ovr;
        int           n, vcount;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, valid, z_flag, ovr_flag, p_out}, '0);
        @(posedge clk); #2 a_reset = 1'b0;

        // 3 * 5
        start_op(16'h0003, 16'h0005, 1'b0);
        wait_result(lo, hi, z, ovr, n);
        chk("3x5_lo", lo, 16'h000F);
        chk("3x5_hi", hi, 16'h0000);
        chk("3x5_flags", {z, ovr}, 2'b00);
        chk("latency_to_outl", 64'(n), 64'd17);
        @(negedge clk);
        chk("valid_drops_after_2", 64'(valid), 64'd0);

        // max * max
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        wait_result(lo, hi, z, ovr, n);
        chk("ffff_lo", lo, 16'h0001);
        chk("ffff_hi", hi, 16'hFFFE);
        chk("ffff_flags", {z, ovr}, 2'b01);

        // zero operand
        start_op(16'h1234, 16'h0000, 1'b0);
        wait_result(lo, hi, z, ovr, n);
        chk("zero_words", {lo, hi}, 32'h0);
        chk("zero_flags", {z, ovr}, 2'b10);

        // ld held high, operands changed mid-CALC
        start_op(16'h0003, 16'h0005, 1'b1);
        repeat (5) @(posedge clk);
        #2 a_in = 16'h0007; b_in = 16'h0009;
        wait_result(lo, hi, z, ovr, n);
        chk("hold_lo_uses_E0_ops", lo, 16'h000F);
        chk("hold_hi", hi, 16'h0000);
        @(negedge clk);
        chk("idle_after_E18", 64'(busy), 64'd0);
        @(negedge clk);
        chk("accept_at_E19", 64'(busy), 64'd1);
        ld = 1'b0;
        wait_result(lo, hi, z, ovr, n);
        chk("second_op_lo", lo, 16'h003F);

        // asynchronous reset mid-CALC
        start_op(16'h1234, 16'h5678, 1'b0);
        repeat (7) @(posedge clk);
        #1 a_reset = 1'b1;
        #1 chk("async_reset_outputs", {busy, valid, z_flag, ovr_flag, p_out}, '0);
        @(posedge clk); #2 a_reset = 1'b0;
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        chk("no_valid_after_abort", 64'(vcount), 64'd0);
        start_op(16'h0100, 16'h0100, 1'b0);
        wait_result(lo, hi, z, ovr, n);
        chk("post_reset_lo", lo, 16'h0000);
        chk("post_reset_hi", hi, 16'h0001);
        chk("post_reset_flags", {z, ovr}, 2'b01);

        // random run; ld and operands toggle freely, including while busy
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #2;
            ld      = ($urandom_range(0, 3) != 0);
            a_in    = rnd_op();
            b_in    = rnd_op();
            a_reset = ($urandom_range(0, 1999) == 0);
        end
        @(posedge clk); #2;
        a_reset = 1'b0; ld = 1'b0;
        repeat (25) @(posedge clk);
        if (nops < 1500) chk("random_op_count", 64'(nops), 64'd1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
